// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt request controller.
package irq_pkg;

  localparam int N_SRC = 4;

  typedef enum logic [1:0] {
    CMD_EOI  = 2'b00,
    CMD_MASK = 2'b01,
    CMD_CLR  = 2'b10,
    CMD_NOP  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FIRE = 2'b01,
    S_WAIT = 2'b10
  } state_e;

  // Lowest set bit wins; bit 0 is the highest-priority source.
  function automatic logic [1:0] lowest_idx(input logic [N_SRC-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (v[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  function automatic logic [N_SRC-1:0] onehot(input logic [1:0] idx);
    return N_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// Multi-stage synchroniser for one asynchronous event line, followed by a
// rising-edge detector that pulses for one clock per captured edge.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ev,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // r_prev resets low, so a line already high at reset release reads as an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ev};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt request controller: latches synchronised event edges as pending
// requests and issues one priority-encoded ie pulse per request, held off until EOI.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] ev,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_we,
  output logic [N_SRC-1:0] ie,
  output logic [7:0]       status,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_ie;
  logic [1:0]       r_act;
  logic             r_busy;
  state_e           r_state;
  state_e           w_state_nxt;

  cmd_e             w_cmd;
  logic             w_eoi;
  logic [1:0]       w_eoi_id;
  logic             w_mask_we;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_elig;
  logic [1:0]       w_sel;
  logic             w_fire;
  logic [N_SRC-1:0] w_fire_clr;
  logic [N_SRC-1:0] w_pending_nxt;
  logic             w_unused_ok;

  for (genvar k = 0; k < N_SRC; k++) begin : g_sync
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk    (clk),
      .reset  (reset),
      .i_ev   (ev[k]),
      .o_rise (w_rise[k])
    );
  end

  assign w_cmd       = cmd_e'(cmd_data[7:6]);
  assign w_eoi       = cmd_we && (w_cmd == CMD_EOI);
  assign w_eoi_id    = cmd_data[1:0];
  assign w_mask_we   = cmd_we && (w_cmd == CMD_MASK);
  assign w_clr       = (cmd_we && (w_cmd == CMD_CLR)) ? cmd_data[3:0] : '0;
  assign w_unused_ok = ^cmd_data[5:4];

  assign w_elig = r_pending & ~r_mask;
  assign w_sel  = lowest_idx(w_elig);

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_elig != '0) begin
          w_fire      = 1'b1;
          w_state_nxt = S_FIRE;
        end
      end
      S_FIRE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_eoi && (w_eoi_id == r_act)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Set beats clear: edges are OR-ed in after every clearing term.
  assign w_fire_clr    = w_fire ? onehot(w_sel) : '0;
  assign w_pending_nxt = (r_pending & ~w_clr & ~w_fire_clr) | w_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_act     <= 2'd0;
      r_ie      <= '0;
      r_busy    <= 1'b0;
      r_pending <= '0;
      r_mask    <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_ie      <= w_fire_clr;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_pending <= w_pending_nxt;
      if (w_fire)    r_act  <= w_sel;
      if (w_mask_we) r_mask <= cmd_data[3:0];
    end
  end

  assign ie        = r_ie;
  assign busy      = r_busy;
  assign status    = {r_mask, r_pending};
  assign dbg_state = r_state;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised bench for irq_ctrl: a cycle-level reference model predicts
// status/busy and queues expected ie pulses; a monitor pops and compares.
module tb_irq_ctrl;
  import irq_pkg::*;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ev = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_we = 1'b0;
  logic [3:0] ie;
  logic [7:0] status;
  logic       busy;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;

  irq_ctrl #(.SYNC_STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .ev        (ev),
    .cmd_data  (cmd_data),
    .cmd_we    (cmd_we),
    .ie        (ie),
    .status    (status),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model state (values after the most recent clock edge)
  int unsigned n = 0;
  logic [3:0]  m_pend = '0;
  logic [3:0]  m_mask = 4'hF;
  logic [3:0]  m_prev = '0;
  int          m_phase = 0;      // 0 idle, 1 issuing, 2 in service
  logic [1:0]  m_act = '0;
  int unsigned arr_due[$];
  int          arr_src[$];
  logic [35:0] exp_q[$];         // {cycle, ie}

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_pend = '0; m_mask = 4'hF; m_prev = '0; m_phase = 0; m_act = '0;
        arr_due.delete(); arr_src.delete(); exp_q.delete();
      end else begin
        logic [3:0]  edges, clr, elig;
        logic        eoi;
        logic [1:0]  eoi_id;
        logic [31:0] cyc;
        int          a;
        n++;
        edges = '0;
        while (arr_due.size() > 0 && arr_due[0] == n) begin
          edges[arr_src[0]] = 1'b1;
          void'(arr_due.pop_front());
          void'(arr_src.pop_front());
        end
        for (int k = 0; k < 4; k++) begin
          if (ev[k] && !m_prev[k]) begin
            arr_due.push_back(n + S);
            arr_src.push_back(k);
          end
        end
        m_prev = ev;
        eoi = 1'b0; eoi_id = cmd_data[1:0]; clr = '0;
        elig = m_pend & ~m_mask;
        if (cmd_we) begin
          case (cmd_data[7:6])
            2'b00: eoi = 1'b1;
            2'b01: m_mask = cmd_data[3:0];
            2'b10: clr = cmd_data[3:0];
            default: ;
          endcase
        end
        if (m_phase == 0) begin
          if (elig != 0) begin
            a = 3;
            for (int k = 3; k >= 0; k--) if (elig[k]) a = k;
            m_act = 2'(a);
            m_pend[a] = 1'b0;
            cyc = n;
            exp_q.push_back({cyc, 4'(1 << a)});
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else if (eoi && eoi_id == m_act) begin
          m_phase = 0;
        end
        m_pend = (m_pend & ~clr) | edges;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        total++;
        if (status !== {m_mask, m_pend}) begin
          bad++;
          $display("FAIL status cyc=%0d got=%h want=%h", n, status, {m_mask, m_pend});
        end
        total++;
        if (busy !== (m_phase != 0)) begin
          bad++;
          $display("FAIL busy cyc=%0d got=%b want=%b", n, busy, (m_phase != 0));
        end
        total++;
        if (ie !== 4'h0) begin
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL ie_unexpected cyc=%0d got=%b want=0000", n, ie);
          end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            if (e[3:0] !== ie || e[35:4] != n) begin
              bad++;
              $display("FAIL ie cyc=%0d got=%b want=%b at cyc %0d", n, ie, e[3:0], e[35:4]);
            end
          end
        end else if (exp_q.size() > 0 && exp_q[0][35:4] <= n) begin
          bad++;
          $display("FAIL ie_missed cyc=%0d got=0000 want=%b", n, exp_q[0][3:0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic write_cmd(input logic [7:0] d);
    cmd_data = d;
    cmd_we   = 1'b1;
    @(negedge clk);
    cmd_we   = 1'b0;
  endtask

  task automatic pulse(input int k, input int len);
    ev[k] = 1'b1;
    tick(len);
    ev[k] = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (ie !== 4'h0 || busy !== 1'b0 || status !== 8'hF0) begin
      bad++;
      $display("FAIL %s got ie=%b busy=%b status=%h want ie=0000 busy=0 status=f0",
               tag, ie, busy, status);
    end
  endtask

  initial begin
    tick(3);
    check_reset_values("reset_state");
    reset = 1'b1;
    tick(2);

    // Single source, unmasked
    write_cmd(8'h40);
    pulse(2, 3);
    tick(4);
    write_cmd(8'h02);
    tick(3);

    // Two sources rising together: priority then service after EOI
    ev[3] = 1'b1; ev[1] = 1'b1;
    tick(2);
    ev = '0;
    tick(5);
    write_cmd(8'h01);
    tick(4);
    write_cmd(8'h03);
    tick(3);

    // Masked request stays pending, fires once unmasked
    write_cmd(8'h4F);
    tick(2);
    pulse(0, 2);
    tick(5);
    write_cmd(8'h40);
    tick(4);
    write_cmd(8'h00);
    tick(3);

    // Wrong-id EOI ignored; re-edge on the active source re-fires after EOI
    pulse(1, 2);
    tick(5);
    write_cmd(8'h00);
    tick(2);
    pulse(1, 2);
    tick(4);
    write_cmd(8'h01);
    tick(5);
    write_cmd(8'h01);
    tick(3);

    // Clear versus same-cycle set
    write_cmd(8'h4F);
    ev[1] = 1'b1; ev[2] = 1'b1;
    tick(2);
    ev = '0;
    tick(4);
    write_cmd(8'h84);
    tick(2);
    ev[2] = 1'b1;
    tick(2);
    write_cmd(8'h84);
    ev[2] = 1'b0;
    tick(2);
    write_cmd(8'h8F);
    write_cmd(8'h40);
    tick(2);

    // Asynchronous reset while in service
    pulse(3, 2);
    tick(5);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    tick(2);
    reset = 1'b1;
    tick(2);

    // Random traffic
    write_cmd(8'h40);
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 7) == 0) ev[$urandom_range(0, 3)] ^= 1'b1;
      r = $urandom_range(0, 15);
      cmd_we = 1'b0;
      if (r <= 4) begin
        cmd_we   = 1'b1;
        cmd_data = {6'b000000, ($urandom_range(0, 3) != 0) ? m_act : 2'($urandom_range(0, 3))};
      end else if (r == 5) begin
        cmd_we   = 1'b1;
        cmd_data = {4'b0100, 4'($urandom_range(0, 15) & $urandom_range(0, 15))};
      end else if (r == 6) begin
        cmd_we   = 1'b1;
        cmd_data = {2'b10, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      end else if (r == 7) begin
        cmd_we   = 1'b1;
        cmd_data = {2'b11, 6'($urandom_range(0, 63))};
      end
      @(negedge clk);
    end
    cmd_we = 1'b0;
    ev = '0;
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
